pc_fetch_sequencer: RTL and testbench



---
 rtl/pc_fetch_sequencer.sv | 83 ++++++++
 tb/tb_pc_fetch_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the program counter and sequences instruction fetches over req/ack
// and hands each instruction to decode over valid/ready, with flush/redirect support.
module pc_fetch_sequencer #(
    parameter int                    ADDR_WIDTH  = 17,
    parameter int                    INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    INCR        = 1
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    input  logic                   Enable,
    input  logic [ADDR_WIDTH-1:0]  NextPc,
    output logic [ADDR_WIDTH-1:0]  PcPlusOne,
    output logic [ADDR_WIDTH-1:0]  Pc,
    input  logic                   Flush,
    input  logic [ADDR_WIDTH-1:0]  FlushPc,
    output logic                   FetchReq,
    output logic [ADDR_WIDTH-1:0]  FetchAddr,
    input  logic                   FetchAck,
    input  logic [INSTR_WIDTH-1:0] FetchData,
    output logic                   InstrValid,
    output logic [INSTR_WIDTH-1:0] Instr,
    input  logic                   InstrReady,
    output logic [31:0]            InstrCount
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [31:0]            count_q, count_d;

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    // DRAIN waits out the ack of an abandoned request so it is never mistaken for the new one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = Enable ? FETCH : IDLE;
            FETCH:   if (Flush) state_d = FetchAck ? FETCH : DRAIN;
                     else if (FetchAck) state_d = HOLD;
            DRAIN:   if (FetchAck) state_d = FETCH;
            HOLD:    if (Flush || InstrReady) state_d = Enable ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flush redirects the PC in every state and outranks a handoff in HOLD.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        if (Flush) begin
            pc_d = FlushPc;
        end else if (state_q == HOLD && InstrReady) begin
            pc_d    = NextPc;
            count_d = count_q + 32'd1;
        end
        if (state_q == FETCH && FetchAck && !Flush) instr_d = FetchData;
    end

    always_comb begin
        FetchReq   = (state_q == FETCH) || (state_q == DRAIN);
        InstrValid = (state_q == HOLD);
        Pc         = pc_q;
        FetchAddr  = pc_q;
        PcPlusOne  = pc_q + ADDR_WIDTH'(INCR);
        Instr      = instr_q;
        InstrCount = count_q;
    end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: randomized transaction-level checks of pc_fetch_sequencer
// against a model of the fetch/handoff protocol kept in the bench.
module tb_pc_fetch_sequencer;
    logic        Clock = 1'b0;
    logic        ResetN, Enable, Flush, FetchAck, InstrReady;
    logic [16:0] NextPc, FlushPc;
    logic [15:0] FetchData;
    logic [16:0] PcPlusOne, Pc, FetchAddr;
    logic        FetchReq, InstrValid;
    logic [15:0] Instr;
    logic [31:0] InstrCount;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] model_pc;
    logic [15:0] model_instr;
    logic [31:0] model_cnt;

    pc_fetch_sequencer dut (
        .Clock(Clock), .ResetN(ResetN), .Enable(Enable), .NextPc(NextPc),
        .PcPlusOne(PcPlusOne), .Pc(Pc), .Flush(Flush), .FlushPc(FlushPc),
        .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchAck(FetchAck),
        .FetchData(FetchData), .InstrValid(InstrValid), .Instr(Instr),
        .InstrReady(InstrReady), .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] mem(input logic [16:0] a);
        return 16'hA000 + a[15:0];
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Leaves the DUT freshly reset with Enable high, sampled in the first fetch cycle.
    task automatic do_reset();
        ResetN = 1'b0; Flush = 1'b0; FetchAck = 1'b0; InstrReady = 1'b0;
        step();
        checks++; if (FetchReq !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", FetchReq); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", InstrValid); end
        checks++; if (Pc !== 17'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", Pc); end
        checks++; if (InstrCount !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", InstrCount); end
        checks++; if (Instr !== 16'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", Instr); end
        model_pc = 17'h0; model_instr = 16'h0; model_cnt = 32'd0;
        ResetN = 1'b1; Enable = 1'b1;
        step();
    endtask

    // One instruction: ack after lat wait cycles, accept after stall cycles, next PC sequential or tgt.
    task automatic do_instr(input int lat, input int stall, input bit redir, input logic [16:0] tgt);
        logic [16:0] nxt;
        logic [16:0] seq;
        seq = model_pc + 17'd1;
        nxt = redir ? tgt : seq;
        for (int i = 0; i <= lat; i++) begin
            checks++; if (FetchReq !== 1'b1) begin errors++; $display("FAIL fetch_req: got %0b want 1", FetchReq); end
            checks++; if (FetchAddr !== model_pc) begin errors++; $display("FAIL fetch_addr: got %h want %h", FetchAddr, model_pc); end
            checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL fetch_valid: got %0b want 0", InstrValid); end
            checks++; if (Instr !== model_instr) begin errors++; $display("FAIL fetch_instr_stable: got %h want %h", Instr, model_instr); end
            FetchAck = (i == lat);
            FetchData = (i == lat) ? mem(model_pc) : 16'hFFFF;
            step();
        end
        FetchAck = 1'b0;
        model_instr = mem(model_pc);
        for (int j = 0; j <= stall; j++) begin
            checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %0b want 1", InstrValid); end
            checks++; if (Instr !== model_instr) begin errors++; $display("FAIL hold_instr: got %h want %h", Instr, model_instr); end
            checks++; if (FetchReq !== 1'b0) begin errors++; $display("FAIL hold_req: got %0b want 0", FetchReq); end
            checks++; if (Pc !== model_pc) begin errors++; $display("FAIL hold_pc: got %h want %h", Pc, model_pc); end
            checks++; if (PcPlusOne !== seq) begin errors++; $display("FAIL pc_plus_one: got %h want %h", PcPlusOne, seq); end
            InstrReady = (j == stall);
            NextPc = redir ? tgt : PcPlusOne;
            step();
        end
        InstrReady = 1'b0;
        model_pc = nxt;
        model_cnt = model_cnt + 32'd1;
        checks++; if (InstrCount !== model_cnt) begin errors++; $display("FAIL count: got %0d want %0d", InstrCount, model_cnt); end
        checks++; if (Pc !== model_pc) begin errors++; $display("FAIL handoff_pc: got %h want %h", Pc, model_pc); end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) do_instr(0, 0, 1'b0, 17'h0);
        checks++; if (InstrCount !== 32'd4) begin errors++; $display("FAIL seq_count4: got %0d want 4", InstrCount); end
    endtask

    task automatic test_ack_delay();
        do_instr(3, 0, 1'b0, 17'h0);
    endtask

    task automatic test_stall_redirect();
        do_instr(0, 5, 1'b1, 17'h00100);
        do_instr(0, 0, 1'b0, 17'h0);
    endtask

    task automatic test_flush_drain();
        Flush = 1'b1; FlushPc = 17'h01234; FetchAck = 1'b0;
        step();
        Flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (FetchReq !== 1'b1) begin errors++; $display("FAIL drain_req: got %0b want 1", FetchReq); end
            checks++; if (FetchAddr !== 17'h01234) begin errors++; $display("FAIL drain_addr: got %h want 01234", FetchAddr); end
            checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %0b want 0", InstrValid); end
            FetchAck = (i == 1); FetchData = 16'hDEAD;
            step();
        end
        FetchAck = 1'b0;
        model_pc = 17'h01234;
        checks++; if (Instr !== model_instr) begin errors++; $display("FAIL drain_instr: got %h want %h", Instr, model_instr); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL drain_discard: got %0b want 0", InstrValid); end
        checks++; if (InstrCount !== model_cnt) begin errors++; $display("FAIL drain_count: got %0d want %0d", InstrCount, model_cnt); end
        do_instr(1, 0, 1'b0, 17'h0);
    endtask

    task automatic flush_with_ack(input logic [16:0] tgt);
        Flush = 1'b1; FlushPc = tgt; FetchAck = 1'b1; FetchData = 16'hBEEF;
        step();
        Flush = 1'b0; FetchAck = 1'b0;
        model_pc = tgt;
        checks++; if (FetchReq !== 1'b1) begin errors++; $display("FAIL flushack_req: got %0b want 1", FetchReq); end
        checks++; if (FetchAddr !== tgt) begin errors++; $display("FAIL flushack_addr: got %h want %h", FetchAddr, tgt); end
        checks++; if (Instr !== model_instr) begin errors++; $display("FAIL flushack_instr: got %h want %h", Instr, model_instr); end
    endtask

    task automatic test_flush_ack();
        flush_with_ack(17'h00555);
        do_instr(0, 0, 1'b0, 17'h0);
    endtask

    task automatic test_wrap();
        flush_with_ack(17'h1FFFF);
        do_instr(1, 0, 1'b0, 17'h0);
        do_instr(0, 0, 1'b0, 17'h0);
    endtask

    task automatic test_flush_hold();
        FetchAck = 1'b1; FetchData = mem(model_pc);
        step();
        FetchAck = 1'b0;
        model_instr = mem(model_pc);
        checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL fh_valid: got %0b want 1", InstrValid); end
        Flush = 1'b1; FlushPc = 17'h00AAA; InstrReady = 1'b1; NextPc = 17'h00777;
        step();
        Flush = 1'b0; InstrReady = 1'b0;
        model_pc = 17'h00AAA;
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL fh_drop: got %0b want 0", InstrValid); end
        checks++; if (FetchAddr !== 17'h00AAA) begin errors++; $display("FAIL fh_addr: got %h want 00aaa", FetchAddr); end
        checks++; if (InstrCount !== model_cnt) begin errors++; $display("FAIL fh_count: got %0d want %0d", InstrCount, model_cnt); end
        do_instr(0, 0, 1'b0, 17'h0);
    endtask

    task automatic test_enable_idle();
        Enable = 1'b0;
        do_instr(2, 1, 1'b0, 17'h0);
        for (int i = 0; i < 2; i++) begin
            checks++; if (FetchReq !== 1'b0) begin errors++; $display("FAIL idle_req: got %0b want 0", FetchReq); end
            checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %0b want 0", InstrValid); end
            step();
        end
        Flush = 1'b1; FlushPc = 17'h00321;
        step();
        Flush = 1'b0;
        model_pc = 17'h00321;
        checks++; if (Pc !== model_pc) begin errors++; $display("FAIL idle_flush_pc: got %h want %h", Pc, model_pc); end
        checks++; if (FetchReq !== 1'b0) begin errors++; $display("FAIL idle_flush_req: got %0b want 0", FetchReq); end
        Enable = 1'b1;
        step();
        do_instr(0, 0, 1'b0, 17'h0);
    endtask

    task automatic test_reset_mid();
        do_instr(0, 0, 1'b0, 17'h0);
        do_reset();
        do_instr(0, 0, 1'b0, 17'h0);
        FetchAck = 1'b1; FetchData = mem(model_pc);
        step();
        FetchAck = 1'b0;
        checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL rm_hold: got %0b want 1", InstrValid); end
        do_reset();
        do_instr(0, 0, 1'b0, 17'h0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 17'($urandom));
    endtask

    initial begin
        ResetN = 1'b0; Enable = 1'b0; Flush = 1'b0; FlushPc = '0; FetchAck = 1'b0;
        FetchData = '0; InstrReady = 1'b0; NextPc = '0;
        test_reset();
        test_sequential();
        test_ack_delay();
        test_stall_redirect();
        test_flush_drain();
        test_flush_ack();
        test_wrap();
        test_flush_hold();
        test_enable_idle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
